// File: rtl/dec_pkg.sv
// Shared encodings and parameter limits for the scanning active-low decoder.
package dec_pkg;

   localparam int unsigned N_MIN     = 2;
   localparam int unsigned N_MAX     = 6;
   localparam int unsigned DWELL_MIN = 1;
   localparam int unsigned DWELL_MAX = 255;

   typedef enum logic [1:0] {
      MODE_DIRECT = 2'b00,
      MODE_SCAN   = 2'b01,
      MODE_STEP   = 2'b10,
      MODE_BLANK  = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_OFF    = 2'b00,
      ST_DRIVE  = 2'b01,
      ST_SETTLE = 2'b10
   } state_e;

   function automatic bit in_range(input int unsigned v, input int unsigned lo,
                                   input int unsigned hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/dec_onehot_n.sv
// Combinational active-low N-to-2**N decoder: only output bit 'sel' is driven low.
module dec_onehot_n #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]    sel,
   output logic [2**N-1:0] y_n
);

   always_comb begin
      y_n      = '1;
      y_n[sel] = 1'b0;
   end

endmodule

// File: rtl/dec_scan_n.sv
// Scanning active-low one-hot decoder with DIRECT/SCAN/STEP/BLANK modes and a
// one-cycle blanking SETTLE state on mode changes.
module dec_scan_n
   import dec_pkg::*;
#(
   parameter int unsigned N     = 4,
   parameter int unsigned DWELL = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic [1:0]      mode,
   input  logic [N-1:0]    addr,
   input  logic            load,
   input  logic            step,
   output logic [2**N-1:0] y_n,
   output logic [N-1:0]    cur,
   output logic            wrap,
   output logic            active
);

   if (!in_range(N, N_MIN, N_MAX) || !in_range(DWELL, DWELL_MIN, DWELL_MAX)) begin : g_bad_param
      $error("dec_scan_n: N or DWELL outside legal range");
   end

   localparam logic [7:0]   DWELL_LAST = 8'(DWELL);
   localparam logic [N-1:0] CUR_MAX    = '1;

   mode_e          mode_v;
   mode_e          mode_q;
   state_e         state;
   logic [N-1:0]   cur_d;
   logic [7:0]     dwell_cnt;
   logic [7:0]     dwell_d;
   logic           go;
   logic           steady;
   logic           adv;
   logic           wrap_d;
   logic [2**N-1:0] dec_y;

   assign mode_v = mode_e'(mode);

   // steady: already driving and staying in DRIVE with the same mode this cycle
   always_comb begin
      go     = en && (mode_v != MODE_BLANK);
      steady = (state == ST_DRIVE) && go && (mode_v == mode_q);
   end

   // en=0 freezes both the address and the dwell count, including any load
   always_comb begin
      cur_d   = cur;
      dwell_d = dwell_cnt;
      adv     = 1'b0;
      if (en) begin
         dwell_d = '0;
         if (load || (mode_v == MODE_DIRECT)) begin
            cur_d = addr;
         end else if (steady && (mode_v == MODE_SCAN)) begin
            if (dwell_cnt + 8'd1 == DWELL_LAST) adv = 1'b1;
            else                                dwell_d = dwell_cnt + 8'd1;
         end else if (steady && (mode_v == MODE_STEP) && step) begin
            adv = 1'b1;
         end
         if (adv) cur_d = cur + 1'b1;
      end
      wrap_d = adv && (cur == CUR_MAX);
   end

   // Decoding the next cur keeps y_n aligned with the registered cur.
   dec_onehot_n #(.N(N)) u_dec (
      .sel (cur_d),
      .y_n (dec_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_OFF;
         mode_q    <= MODE_BLANK;
         cur       <= '0;
         dwell_cnt <= '0;
         wrap      <= 1'b0;
         y_n       <= '1;
         active    <= 1'b0;
      end else begin
         mode_q    <= mode_v;
         cur       <= cur_d;
         dwell_cnt <= dwell_d;
         wrap      <= wrap_d;
         case (state)
            ST_DRIVE: begin
               if (!go) begin
                  state  <= ST_OFF;
                  y_n    <= '1;
                  active <= 1'b0;
               end else if (mode_v != mode_q) begin
                  state  <= ST_SETTLE;
                  y_n    <= '1;
                  active <= 1'b0;
               end else begin
                  y_n    <= dec_y;
                  active <= 1'b1;
               end
            end
            default: begin
               if (go) begin
                  state  <= ST_DRIVE;
                  y_n    <= dec_y;
                  active <= 1'b1;
               end else begin
                  state  <= ST_OFF;
                  y_n    <= '1;
                  active <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dec_scan_n.sv
// Bench for dec_scan_n: directed table and hand sequences on an N=4/DWELL=3 instance,
// plus random stimulus on N=2..6 instances checked against a behavioural model.
module tb_dec_scan_n;

   localparam logic [1:0] D = 2'd0, S = 2'd1, T = 2'd2, B = 2'd3;

   typedef struct {
      logic        en;
      logic [1:0]  mode;
      logic [3:0]  addr;
      logic        load;
      logic        step;
      logic [15:0] y;
      logic [3:0]  c;
      logic        w;
      logic        a;
   } vec_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        en    = 1'b0;
   logic        load  = 1'b0;
   logic        step  = 1'b0;
   logic [1:0]  mode  = 2'd3;
   logic [5:0]  addr  = '0;
   logic [15:0] y_n;
   logic [3:0]  cur;
   logic        wrap;
   logic        active;

   int   total = 0;
   int   bad   = 0;
   event step_ev, chk_ev, rst_ev;

   always #5 clk = ~clk;

   dec_scan_n #(.N(4), .DWELL(3)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .mode   (mode),
      .addr   (addr[3:0]),
      .load   (load),
      .step   (step),
      .y_n    (y_n),
      .cur    (cur),
      .wrap   (wrap),
      .active (active)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 30) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Models step from inputs held stable up to the coming rising edge.
   task automatic cyc();
      #1 -> step_ev;
      @(posedge clk);
      @(negedge clk);
      -> chk_ev;
   endtask

   task automatic clk_then_reset();
      #1 -> step_ev;
      @(posedge clk);
      #2 rst_n = 1'b0;
      -> rst_ev;
      #2 rst_n = 1'b1;
      @(negedge clk);
      -> chk_ev;
   endtask

   function automatic vec_t mk(input logic e, input logic [1:0] m, input logic [3:0] ad,
                               input logic ld, input logic st, input logic [15:0] y,
                               input logic [3:0] c, input logic w, input logic a);
      vec_t v;
      v.en = e; v.mode = m; v.addr = ad; v.load = ld; v.step = st;
      v.y = y; v.c = c; v.w = w; v.a = a;
      return v;
   endfunction

   for (genvar g = 0; g < 5; g++) begin : g_rnd
      localparam int NN = g + 2;
      localparam int DW = 2 * g + 1;
      localparam int W  = 1 << NN;

      logic [W-1:0]  ry;
      logic [NN-1:0] rc;
      logic          rw, ra;
      int            ph = 0;
      int            cm = 0;
      int            held = 0;
      int            last_mode = 3;
      bit            wm = 1'b0;

      dec_scan_n #(.N(NN), .DWELL(DW)) u_dut (
         .clk    (clk),
         .rst_n  (rst_n),
         .en     (en),
         .mode   (mode),
         .addr   (addr[NN-1:0]),
         .load   (load),
         .step   (step),
         .y_n    (ry),
         .cur    (rc),
         .wrap   (rw),
         .active (ra)
      );

      // ph: 0 dark, 1 lit, 2 settling after a mode change
      always @(step_ev or rst_ev) begin : model
         bit lit, same, adv;
         if (!rst_n) begin
            ph = 0; cm = 0; held = 0; last_mode = 3; wm = 1'b0;
         end else begin
            lit  = en && (mode != 2'd3);
            same = (ph == 1) && lit && (int'(mode) == last_mode);
            adv  = 1'b0;
            wm   = 1'b0;
            if (en) begin
               if (same && mode == 2'd1 && !load) held++;
               else                                held = 0;
               if (!load && same && ((mode == 2'd1 && held == DW) || (mode == 2'd2 && step)))
                  adv = 1'b1;
               if (adv) begin
                  held = 0;
                  wm   = (cm == W - 1);
               end
               if (load || mode == 2'd0) cm = int'(addr[NN-1:0]);
               else if (adv)             cm = (cm + 1) % W;
            end
            ph = !lit ? 0 : (ph == 1 && int'(mode) != last_mode) ? 2 : 1;
            last_mode = int'(mode);
         end
      end

      always @(chk_ev) begin : check
         logic [W-1:0] ey;
         ey = '1;
         if (ph == 1) ey[cm] = 1'b0;
         chk($sformatf("y_n N=%0d", NN), 64'(ry), 64'(ey));
         chk($sformatf("cur N=%0d", NN), 64'(rc), 64'(cm));
         chk($sformatf("wrap N=%0d", NN), 64'(rw), 64'(wm));
         chk($sformatf("active N=%0d", NN), 64'(ra), 64'(ph == 1));
         chk($sformatf("multi-low N=%0d", NN), 64'($countones(~ry) > 1), 64'd0);
         chk($sformatf("active-vs-y N=%0d", NN), 64'(ra), 64'($countones(~ry) == 1));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish within time limit");
      $fatal(1);
   end

   initial begin
      vec_t tbl[$];
      int   ec[8];
      int   ew[8];
      int   rc[4];

      tbl.push_back(mk(1'b1, D, 4'd5,  1'b0, 1'b0, 16'hFFDF, 4'd5,  1'b0, 1'b1));
      tbl.push_back(mk(1'b1, D, 4'd10, 1'b0, 1'b0, 16'hFBFF, 4'd10, 1'b0, 1'b1));
      tbl.push_back(mk(1'b0, D, 4'd3,  1'b0, 1'b0, 16'hFFFF, 4'd10, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, B, 4'd3,  1'b1, 1'b0, 16'hFFFF, 4'd3,  1'b0, 1'b0));
      tbl.push_back(mk(1'b1, T, 4'd0,  1'b0, 1'b1, 16'hFFF7, 4'd3,  1'b0, 1'b1));
      tbl.push_back(mk(1'b1, T, 4'd0,  1'b0, 1'b1, 16'hFFEF, 4'd4,  1'b0, 1'b1));
      tbl.push_back(mk(1'b1, T, 4'd0,  1'b0, 1'b0, 16'hFFEF, 4'd4,  1'b0, 1'b1));
      tbl.push_back(mk(1'b1, T, 4'd9,  1'b1, 1'b1, 16'hFDFF, 4'd9,  1'b0, 1'b1));
      tbl.push_back(mk(1'b1, T, 4'd0,  1'b0, 1'b1, 16'hFBFF, 4'd10, 1'b0, 1'b1));
      tbl.push_back(mk(1'b1, T, 4'd15, 1'b1, 1'b0, 16'h7FFF, 4'd15, 1'b0, 1'b1));
      tbl.push_back(mk(1'b1, T, 4'd0,  1'b0, 1'b1, 16'hFFFE, 4'd0,  1'b1, 1'b1));
      tbl.push_back(mk(1'b1, T, 4'd0,  1'b0, 1'b0, 16'hFFFE, 4'd0,  1'b0, 1'b1));
      tbl.push_back(mk(1'b1, T, 4'd5,  1'b1, 1'b0, 16'hFFDF, 4'd5,  1'b0, 1'b1));
      tbl.push_back(mk(1'b1, T, 4'd0,  1'b1, 1'b0, 16'hFFFE, 4'd0,  1'b0, 1'b1));
      tbl.push_back(mk(1'b1, S, 4'd0,  1'b0, 1'b0, 16'hFFFF, 4'd0,  1'b0, 1'b0));
      tbl.push_back(mk(1'b1, S, 4'd0,  1'b0, 1'b0, 16'hFFFE, 4'd0,  1'b0, 1'b1));
      tbl.push_back(mk(1'b1, S, 4'd0,  1'b0, 1'b1, 16'hFFFE, 4'd0,  1'b0, 1'b1));
      tbl.push_back(mk(1'b1, S, 4'd0,  1'b0, 1'b0, 16'hFFFE, 4'd0,  1'b0, 1'b1));
      tbl.push_back(mk(1'b1, S, 4'd0,  1'b0, 1'b0, 16'hFFFD, 4'd1,  1'b0, 1'b1));
      tbl.push_back(mk(1'b1, D, 4'd7,  1'b0, 1'b0, 16'hFFFF, 4'd7,  1'b0, 1'b0));
      tbl.push_back(mk(1'b1, D, 4'd7,  1'b0, 1'b0, 16'hFF7F, 4'd7,  1'b0, 1'b1));
      tbl.push_back(mk(1'b1, B, 4'd2,  1'b0, 1'b0, 16'hFFFF, 4'd7,  1'b0, 1'b0));

      ec = '{14, 14, 14, 15, 15, 15, 0, 0};
      ew = '{0, 0, 0, 0, 0, 0, 1, 0};
      rc = '{0, 0, 0, 1};

      #1 -> rst_ev;
      repeat (2) @(posedge clk);
      #1;
      chk("reset y_n", 64'(y_n), 64'hFFFF);
      chk("reset cur", 64'(cur), 64'd0);
      chk("reset wrap", 64'(wrap), 64'd0);
      chk("reset active", 64'(active), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         en = tbl[i].en; mode = tbl[i].mode; addr = {2'b00, tbl[i].addr};
         load = tbl[i].load; step = tbl[i].step;
         cyc();
         chk($sformatf("vec%0d y_n", i), 64'(y_n), 64'(tbl[i].y));
         chk($sformatf("vec%0d cur", i), 64'(cur), 64'(tbl[i].c));
         chk($sformatf("vec%0d wrap", i), 64'(wrap), 64'(tbl[i].w));
         chk($sformatf("vec%0d active", i), 64'(active), 64'(tbl[i].a));
      end

      // SCAN from 14 with dwell 3 through the wrap to 0
      for (int i = 0; i < 8; i++) begin
         en = 1'b1; mode = S; addr = 6'd14; load = (i == 0); step = 1'b0;
         cyc();
         chk($sformatf("scan cur[%0d]", i), 64'(cur), 64'(ec[i]));
         chk($sformatf("scan wrap[%0d]", i), 64'(wrap), 64'(ew[i]));
      end

      // SCAN -> STEP passes through one blank settle cycle
      mode = T;
      cyc();
      chk("settle y_n", 64'(y_n), 64'hFFFF);
      chk("settle active", 64'(active), 64'd0);
      chk("settle cur", 64'(cur), 64'd0);
      cyc();
      chk("post-settle y_n", 64'(y_n), 64'hFFFE);
      chk("post-settle active", 64'(active), 64'd1);

      // Asynchronous reset in the middle of a scan at address 7
      mode = S; load = 1'b1; addr = 6'd7;
      cyc();
      load = 1'b0;
      cyc();
      chk("mid-scan y_n", 64'(y_n), 64'hFF7F);
      #1 -> step_ev;
      @(posedge clk);
      #2 rst_n = 1'b0;
      -> rst_ev;
      #1;
      chk("async reset y_n", 64'(y_n), 64'hFFFF);
      chk("async reset cur", 64'(cur), 64'd0);
      chk("async reset active", 64'(active), 64'd0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      -> chk_ev;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk($sformatf("restart cur[%0d]", i), 64'(cur), 64'(rc[i]));
         chk($sformatf("restart active[%0d]", i), 64'(active), 64'd1);
      end
      chk("restart y_n", 64'(y_n), 64'hFFFD);

      for (int i = 0; i < 10000; i++) begin
         en = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 7) == 0) mode = 2'($urandom);
         load = ($urandom_range(0, 11) == 0);
         step = 1'($urandom);
         addr = 6'($urandom);
         if ($urandom_range(0, 999) == 0) clk_then_reset();
         else                             cyc();
         chk("main multi-low", 64'($countones(~y_n) > 1), 64'd0);
         chk("main active-vs-y", 64'(active), 64'($countones(~y_n) == 1));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dec_scan_n.md
DEC_SCAN_N -- requirements
Module: dec_scan_n

Interface
REQ-001 Parameter N, default 4: address width; output width 2**N; legal range 2..6.
REQ-002 Parameter DWELL, default 1: clock cycles each address is held in SCAN mode; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  enable; low blanks outputs and freezes the address counter.
REQ-006 mode  input  2  00 DIRECT, 01 SCAN, 10 STEP, 11 BLANK.
REQ-007 addr  input  N  address for DIRECT mode and load value.
REQ-008 load  input  1  one-cycle strobe; copies addr into the counter.
REQ-009 step  input  1  one-cycle strobe; advances the counter in STEP mode.
REQ-010 y_n  output  2**N  registered, active-low one-hot decode; only bit cur is low.
REQ-011 cur  output  N  registered current address.
REQ-012 wrap  output  1  one-cycle pulse when the counter rolls from 2**N-1 to 0.
REQ-013 active  output  1  high when y_n has exactly one low bit.

Function
REQ-014 The FSM SHALL have three states: OFF (y_n all ones), DRIVE (y_n decodes cur), and SETTLE (one cycle, y_n all ones, entered on any mode change).
REQ-015 OFF->DRIVE SHALL occur when en=1 and mode!=BLANK; DRIVE->OFF SHALL occur when en=0 or mode=BLANK; DRIVE->SETTLE SHALL occur on a mode change between non-BLANK modes; SETTLE->DRIVE SHALL occur after one cycle.
REQ-016 DIRECT: cur SHALL take addr each cycle; y_n SHALL reflect addr with 1-cycle latency.
REQ-017 SCAN: the counter SHALL advance by 1 modulo 2**N after DWELL consecutive DRIVE cycles on the same address; the dwell counter SHALL restart at every advance, load, or entry to DRIVE.
REQ-018 STEP: the counter SHALL advance by 1 modulo 2**N on each cycle with step=1 in DRIVE; step outside STEP mode SHALL be ignored.
REQ-019 load=1 SHALL override advance in the same cycle in SCAN and STEP, and SHALL be accepted in OFF and SETTLE (counter updated, outputs stay blank).
REQ-020 wrap SHALL pulse for exactly one cycle, in the cycle cur becomes 0 by advance; load to 0 SHALL NOT pulse wrap.
REQ-021 en=0 SHALL hold cur and the dwell count; on re-enable, SCAN SHALL resume with a fresh dwell.
REQ-022 active SHALL equal (state==DRIVE), registered with y_n.
REQ-023 At no cycle SHALL y_n have more than one low bit.

Reset
REQ-024 While rst_n=0: state=OFF, y_n all ones, cur=0, dwell count=0, wrap=0, active=0.
REQ-025 Reset assertion mid-scan SHALL blank y_n immediately (asynchronously), without waiting for a clock edge.
REQ-026 After rst_n deasserts, the first DRIVE cycle SHALL decode address 0 unless load or DIRECT supplies another.

Structure
REQ-027 Mode encodings, FSM state encodings, and the N/DWELL legal-range limits SHALL live in a shared package, dec_pkg.
REQ-028 The combinational active-low N-to-2**N decode SHALL be a sub-module, dec_onehot_n, instantiated once and fed by cur; y_n registers and FSM are in dec_scan_n.

Verification
REQ-029 Reset, then en=1, mode=DIRECT, addr=5 (N=4) -> after 1 clock y_n=16'hFFDF, cur=5, active=1.
REQ-030 N=4, DWELL=3, mode=SCAN from cur=14 -> cur 14 held 3 cycles, then 15 held 3 cycles, then 0 with wrap=1 for exactly one cycle.
REQ-031 mode=STEP, step pulsed together with load, addr=9 -> cur=9 with no advance; next step -> cur=10.
REQ-032 DRIVE in SCAN, switch to STEP -> one SETTLE cycle with y_n=16'hFFFF and active=0, then DRIVE at the unchanged cur.
REQ-033 Mid-scan at cur=7, rst_n pulled low between clock edges -> y_n=16'hFFFF and cur=0 before the next edge; scan restarts at 0.
REQ-034 Random stimulus over all modes, 10k cycles, N=2..6 -> y_n is never multi-low, and active=1 exactly when y_n has one low bit.
